// File: rtl/riscv_core_pkg.sv
// Shared core definitions: datapath width, fetch FSM states, and the IF/ID latch payload.
package riscv_core_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned INST_BYTES = 4;

  // Bubble instruction: addi x0,x0,0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Contents of the IF/ID pipeline latch
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/fetch_pc_select.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   state             in   current fetch FSM state
//   pc                in   current PC
//   stall             in   hazard-unit hold
//   redirect_valid    in   branch/jump redirect request
//   redirect_target   in   redirect byte address
//   next_pc_c         out  PC to load on the next edge
//   flush_c           out  IF/ID must be flushed this edge
//   misalign_c        out  redirect target is not word aligned
//   pc_in_range_c     out  a full word at pc lies inside the memory
//   target_in_range_c out  a full word at the aligned target lies inside the memory
module fetch_pc_select
  import riscv_core_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 96
) (
  input  fetch_state_t    state,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] next_pc_c,
  output logic            flush_c,
  output logic            misalign_c,
  output logic            pc_in_range_c,
  output logic            target_in_range_c
);

  localparam int unsigned     AW    = XLEN + 1;
  localparam logic [AW-1:0]   LIMIT = AW'(MEM_BYTES);

  logic [XLEN-1:0] aligned_target;

  // Range test done one bit wider so a PC near the top of the space cannot wrap into range
  function automatic logic word_in_range(input logic [XLEN-1:0] addr);
    return (AW'(addr) + AW'(INST_BYTES - 1)) < LIMIT;
  endfunction

  assign aligned_target    = {redirect_target[XLEN-1:2], 2'b00};
  assign flush_c           = redirect_valid;
  assign misalign_c        = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign pc_in_range_c     = word_in_range(pc);
  assign target_in_range_c = word_in_range(aligned_target);

  // Redirect beats stall; PC only advances when RUN captures an in-range word
  always_comb begin
    next_pc_c = pc;
    if (redirect_valid) begin
      next_pc_c = aligned_target;
    end else if (!stall && (state == RUN) && pc_in_range_c) begin
      next_pc_c = pc + XLEN'(INST_BYTES);
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// IF stage sequencer: owns the PC, drives the instruction memory address, applies stalls
// and redirects, registers the IF/ID latch, and halts when the PC leaves the memory.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   stall             hold PC and IF/ID
//   redirect_valid    load redirect_target (aligned) and flush IF/ID
//   redirect_target   redirect byte address
//   Instruction       memory read data for Inst_Address
//   Inst_Address      current PC
//   ifid_pc/inst/valid IF/ID latch contents
//   halted            fetch FSM is in HALT
//   misalign_err      sticky flag: a redirect target was not word aligned
module instruction_fetch_controller
  import riscv_core_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 96,
  parameter logic [31:0] NOP_INST  = riscv_core_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic [INST_W-1:0] Instruction,
  output logic [XLEN-1:0]   Inst_Address,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic              ifid_valid,
  output logic              halted,
  output logic              misalign_err
);

  localparam ifid_t BUBBLE = '{pc: '0, inst: NOP_INST, valid: 1'b0};

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  ifid_t           ifid_q, ifid_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] next_pc_c;
  logic            flush_c;
  logic            misalign_c;
  logic            pc_in_range_c;
  logic            target_in_range_c;

  fetch_pc_select #(
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_select (
    .state             (state_q),
    .pc                (pc_q),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .next_pc_c         (next_pc_c),
    .flush_c           (flush_c),
    .misalign_c        (misalign_c),
    .pc_in_range_c     (pc_in_range_c),
    .target_in_range_c (target_in_range_c)
  );

  // Next-state and IF/ID update
  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    err_d   = err_q | misalign_c;
    case (state_q)
      RUN: begin
        if (flush_c) begin
          ifid_d = BUBBLE;
        end else if (!stall) begin
          if (pc_in_range_c) begin
            ifid_d = '{pc: pc_q, inst: Instruction, valid: 1'b1};
          end else begin
            ifid_d  = BUBBLE;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (flush_c) begin
          ifid_d  = BUBBLE;
          state_d = target_in_range_c ? RUN : HALT;
        end else if (!stall) begin
          ifid_d = BUBBLE;
        end
      end
      default: begin
        ifid_d  = BUBBLE;
        state_d = RUN;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  // State, PC, IF/ID and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifid_q   <= BUBBLE;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= next_pc_c;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign Inst_Address = pc_q;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_inst    = ifid_q.inst;
  assign ifid_valid   = ifid_q.valid;
  assign halted       = halted_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios plus random stall/redirect/reset
// traffic, all compared against a cycle-level behavioural model of the fetch stage.
module tb_instruction_fetch_controller;

  localparam int unsigned MEM_BYTES = 96;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic [31:0] instruction;
  logic [63:0] inst_address;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        halted;
  logic        misalign_err;

  logic [31:0] imem [WORDS];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic [63:0] m_ifid_pc;
  logic [31:0] m_ifid_inst;
  logic        m_valid;
  logic        m_halted;
  logic        m_err;

  always #5 clk = ~clk;

  instruction_fetch_controller #(
    .RESET_PC  (64'd0),
    .MEM_BYTES (MEM_BYTES),
    .NOP_INST  (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .Instruction     (instruction),
    .Inst_Address    (inst_address),
    .ifid_pc         (ifid_pc),
    .ifid_inst       (ifid_inst),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  // A whole 4-byte word at addr exists in the memory
  function automatic bit fits(input logic [63:0] addr);
    return addr <= 64'(MEM_BYTES - 4);
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    if (fits(addr)) return imem[addr[6:2]];
    return 32'hBAD0_0000 | 32'(addr[15:0]);
  endfunction

  assign instruction = mem_word(inst_address);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_ifid_pc   = 64'd0;
    m_ifid_inst = NOP;
    m_valid     = 1'b0;
  endtask

  // One clock edge of the fetch stage as described behaviourally
  task automatic model_edge(input logic r, input logic s, input logic rv, input logic [63:0] t);
    if (r) begin
      m_pc = 64'd0; model_bubble(); m_halted = 1'b0; m_err = 1'b0;
    end else if (rv) begin
      if (t % 4 != 0) m_err = 1'b1;
      m_pc = t - (t % 4);
      model_bubble();
      if (fits(m_pc)) m_halted = 1'b0;
    end else if (m_halted) begin
      if (!s) model_bubble();
    end else if (s) begin
      // everything holds
    end else if (!fits(m_pc)) begin
      model_bubble();
      m_halted = 1'b1;
    end else begin
      m_ifid_pc   = m_pc;
      m_ifid_inst = mem_word(m_pc);
      m_valid     = 1'b1;
      m_pc        = m_pc + 64'd4;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [63:0] t);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t;
    model_edge(r, s, rv, t);
    @(posedge clk);
    #1;
    check_eq("pc",       inst_address,       m_pc);
    check_eq("ifid_pc",  ifid_pc,            m_ifid_pc);
    check_eq("ifid_inst", 64'(ifid_inst),    64'(m_ifid_inst));
    check_eq("ifid_valid", 64'(ifid_valid),  64'(m_valid));
    check_eq("halted",   64'(halted),        64'(m_halted));
    check_eq("misalign", 64'(misalign_err),  64'(m_err));
  endtask

  task automatic adv();
    step(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) imem[i] = 32'h0010_0093 + (32'(i) << 15);
    imem[0]  = 32'h0080_0513;
    imem[1]  = 32'h0050_0693;
    imem[18] = 32'h0017_8a93;
    imem[23] = 32'hEC7F_F0EF;
    m_pc = '0; m_ifid_pc = '0; m_ifid_inst = NOP; m_valid = 0; m_halted = 0; m_err = 0;

    // Reset and free-running fetch
    step(1'b1, 1'b0, 1'b0, 64'd0);
    check_eq("rst_pc", inst_address, 64'd0);
    check_eq("rst_valid", 64'(ifid_valid), 64'd0);
    check_eq("rst_inst", 64'(ifid_inst), 64'(NOP));
    adv();
    check_eq("t1_inst0", 64'(ifid_inst), 64'h0080_0513);
    check_eq("t1_pc4", inst_address, 64'd4);
    adv();
    check_eq("t1_pc8", inst_address, 64'd8);
    check_eq("t1_lag", ifid_pc, 64'd4);

    // Stall holds PC and IF/ID
    step(1'b0, 1'b1, 1'b0, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check_eq("t2_hold_pc", inst_address, 64'd8);
    check_eq("t2_hold_inst", 64'(ifid_inst), 64'h0050_0693);
    adv();
    check_eq("t2_resume", inst_address, 64'd12);

    // Redirect wins over stall
    step(1'b0, 1'b1, 1'b1, 64'h48);
    check_eq("t3_pc", inst_address, 64'h48);
    check_eq("t3_flush", 64'(ifid_valid), 64'd0);
    adv();
    check_eq("t3_cap", 64'(ifid_inst), 64'h0017_8a93);

    // Run to the end of memory, halt, recover
    for (int i = 0; i < 8 && m_pc != 64'd92; i++) adv();
    adv();
    check_eq("t4_last", 64'(ifid_inst), 64'hEC7F_F0EF);
    check_eq("t4_pc96", inst_address, 64'd96);
    adv();
    check_eq("t4_halt", 64'(halted), 64'd1);
    adv();
    step(1'b0, 1'b1, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b1, 64'h0C);
    check_eq("t4_unhalt", 64'(halted), 64'd0);
    adv();
    check_eq("t4_resume", ifid_pc, 64'h0C);

    // Misaligned redirect is sticky
    step(1'b0, 1'b0, 1'b1, 64'h13);
    check_eq("t5_align", inst_address, 64'h10);
    check_eq("t5_err", 64'(misalign_err), 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    adv();
    check_eq("t5_sticky", 64'(misalign_err), 64'd1);

    // Redirect into halt range and to a huge address
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    adv();
    check_eq("big_halt", 64'(halted), 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'd93);
    step(1'b0, 1'b0, 1'b1, 64'd100);

    // Reset while stalled mid-run
    step(1'b0, 1'b0, 1'b1, 64'h30);
    step(1'b1, 1'b1, 1'b0, 64'd0);
    check_eq("t6_pc", inst_address, 64'd0);
    check_eq("t6_err", 64'(misalign_err), 64'd0);
    check_eq("t6_halt", 64'(halted), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic        r, s, rv;
      logic [63:0] t;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 104));
      step(r, s, rv, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
